// File: rtl/divu_pkg.sv
// Shared definitions for the unsigned divider and the ALU-control decode.
// Optional build macro affecting divu_unit: DIVU_DIVZ_DETECT_EN.
package divu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MULTU = 6'b011001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divu_state_t;

  function automatic logic is_long_op(input logic [5:0] funct);
    return (funct == DIVU) || (funct == MULTU);
  endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift in a dividend bit, then conditionally
// subtract the divisor using WIDTH+1-bit unsigned arithmetic.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remainder,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] remainder_next,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] selected;
  logic           msb_unused;

  assign shifted      = {remainder, bit_in};
  assign quotient_bit = (shifted >= {1'b0, divisor});
  assign diff         = shifted - {1'b0, divisor};
  assign selected     = quotient_bit ? diff : shifted;

  // The remainder stays below the divisor, so the top bit is always zero here.
  assign {msb_unused, remainder_next} = selected;

endmodule

// File: rtl/divu_unit.sv
// Multi-cycle unsigned restoring divider producing {remainder, quotient}.
// Define DIVU_DIVZ_DETECT_EN to short-circuit a zero divisor straight to DONE.
module divu_unit #(
  parameter int WIDTH = divu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  import divu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  divu_state_t      state;
  logic             armed;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .remainder      (rem_q),
    .divisor        (divisor_q),
    .bit_in         (dividend_q[WIDTH-1]),
    .remainder_next (rem_next),
    .quotient_bit   (q_bit)
  );

  // armed is a one-stage release synchroniser: starts are taken from the second edge on.
  // The dividend register shifts left each step and fills with quotient bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      count       <= '0;
      dataOut     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && armed) begin
            dividend_q  <= dataA;
            divisor_q   <= dataB;
            rem_q       <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVU_DIVZ_DETECT_EN
            if (dataB == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              dataOut     <= {dataA, {WIDTH{1'b1}}};
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (count == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dataOut <= {rem_q, dividend_q};
          end else begin
            rem_q      <= rem_next;
            dividend_q <= {dividend_q[WIDTH-2:0], q_bit};
            count      <= count + CW'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_unit.sv
// Scoreboard bench for divu_unit: stimulus pushes model results, a monitor pops on done.
// Honours DIVU_DIVZ_DETECT_EN for the zero-divisor expectations.
module tb_divu_unit;

  localparam int W = 32;

`ifdef DIVU_DIVZ_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] data;
    logic           dz;
    int             doneEdge;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   dataA = '0;
  logic [W-1:0]   dataB = '0;
  logic [2*W-1:0] dataOut;
  logic           busy;
  logic           done;
  logic           div_by_zero;

  int   cycleCount = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon;

  divu_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataA       (dataA),
    .dataB       (dataB),
    .dataOut     (dataOut),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Reference: plain integer division, with the zero-divisor convention.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int startEdge);
    exp_t r;
    longint unsigned ua = a;
    longint unsigned ub = b;
    if (b == '0) begin
      r.data     = {a, {W{1'b1}}};
      r.dz       = DETECT;
      r.doneEdge = DETECT ? startEdge : startEdge + W + 1;
    end else begin
      r.data     = {W'(ua % ub), W'(ua / ub)};
      r.dz       = 1'b0;
      r.doneEdge = startEdge + W + 1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cycleCount);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit track, output int startEdge);
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout actual=busy expected=idle");
    end
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    startEdge = cycleCount;
    if (track) sb.push_back(model(a, b, startEdge));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=done=1 expected=done=0 at cycle %0d", cycleCount);
      end else begin
        mon = sb.pop_front();
        checkOutput("dataOut", dataOut, mon.data);
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(mon.dz));
        checkOutput("done_cycle", 64'(cycleCount), 64'(mon.doneEdge));
        checkOutput("busy_with_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int e;
    int guard;
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (3) @(negedge clk);
    checkOutput("reset_dataOut", dataOut, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b1;
    @(posedge clk);

    applyStimulus(32'd100, 32'd7, 1'b1, e);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b1, e);
    applyStimulus(32'd5, 32'd9, 1'b1, e);
    applyStimulus(32'h1234_5678, 32'd0, 1'b1, e);
    drain();

    // Start pulses while running and while in DONE must both be ignored.
    applyStimulus(32'd100, 32'd7, 1'b1, e);
    while (cycleCount < e + 9) @(negedge clk);
    dataA = 32'd9;
    dataB = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset in the middle of a divide aborts it without a done pulse.
    applyStimulus(32'd100, 32'd7, 1'b0, e);
    while (cycleCount < e + 15) @(negedge clk);
    reset = 1'b0;
    while (cycleCount < e + 17) @(negedge clk);
    reset = 1'b1;
    checkOutput("abort_dataOut", dataOut, 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    applyStimulus(32'd9, 32'd3, 1'b1, e);
    drain();

    // Operand changes after the start edge must not disturb the result.
    applyStimulus(32'd100, 32'd7, 1'b1, e);
    guard = 0;
    while (!done && guard < 60) begin
      dataA = $urandom;
      dataB = $urandom;
      @(negedge clk);
      guard++;
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = W'($urandom_range(1, 17));
        2: b = '0;
        default: begin
          b = $urandom;
          a = (b == '0) ? '0 : W'($urandom % b);
        end
      endcase
      applyStimulus(a, b, 1'b1, e);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
